// File: rtl/uart_pkg.sv
// Shared UART constants and the TX-FIFO launcher state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;
    localparam int unsigned BAUD_RATE       = 9600;
    localparam int unsigned CLOCK_FREQUENCY = 100_000_000;
    localparam int unsigned CLKS_PER_BIT    = CLOCK_FREQUENCY / BAUD_RATE;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StBusy   = 2'd2,
        StGap    = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full/empty come straight from registers.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic                    i_rd_en,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic                  push;
    logic                  pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_level = wr_ptr_q - rd_ptr_q;

    // A write while full is dropped even if a pop frees a slot on the same edge.
    assign push = i_wr_en && !o_full;
    assign pop  = i_rd_en && !o_empty;

    assign o_rd_data = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart_tx: pops one byte per frame and issues a one-cycle start pulse.
// Define UART_TX_FIFO_OVERFLOW_EN to add the sticky o_overflow flag for dropped writes.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_tx_dv,
    output logic [DATA_WIDTH-1:0]   o_tx_byte,
    input  logic                    i_tx_active,
    input  logic                    i_tx_done
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    output logic                    o_overflow
`endif
);

    tx_state_e             state_q;
    logic                  tx_dv_q;
    logic [DATA_WIDTH-1:0] tx_byte_q;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_pop;

    uart_sync_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .i_rd_en   (fifo_pop),
        .o_rd_data (fifo_rd_data),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_level   (o_level)
    );

    assign fifo_pop = (state_q == StIdle) && !o_empty && !i_tx_active;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            tx_dv_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fifo_pop) begin
                        state_q   <= StLaunch;
                        tx_dv_q   <= 1'b1;
                        tx_byte_q <= fifo_rd_data;
                    end
                end
                StLaunch: state_q <= StBusy;
                StBusy:   if (i_tx_done) state_q <= StGap;
                // One idle cycle lets uart_tx settle before the next start pulse.
                StGap:    state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign o_tx_dv   = tx_dv_q;
    assign o_tx_byte = tx_byte_q;

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
        end else if (i_wr_en && o_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign o_overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with a behavioural uart_tx stand-in and a byte scoreboard.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned FRAME = 16;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic       stall;
    logic       act_in;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic       overflow;
`endif

    assign act_in = tx_active | stall;

    uart_tx_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data),
        .o_full      (full),
        .o_empty     (empty),
        .o_level     (level),
        .o_tx_dv     (tx_dv),
        .o_tx_byte   (tx_byte),
        .i_tx_active (act_in),
        .i_tx_done   (tx_done)
`ifdef UART_TX_FIFO_OVERFLOW_EN
        ,
        .o_overflow  (overflow)
`endif
    );

    int unsigned checks    = 0;
    int unsigned errors    = 0;
    int unsigned cyc       = 0;
    int unsigned dv_count  = 0;
    int unsigned done_cyc  = 0;
    int unsigned wr_cyc    = 0;
    bit          chk_lat   = 0;
    bit          chk_gap   = 0;
    bit          chk_stab  = 0;
    bit          have_done = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];

    typedef struct {
        logic [7:0] data;
        logic       accept;
        logic [4:0] exp_level;
        logic       exp_full;
        logic       exp_empty;
    } vec_t;
    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // uart_tx stand-in: acts 1 unit after each edge, frame of FRAME cycles then a done pulse.
    initial begin : uart_model
        int unsigned busy_cnt;
        logic        prev_dv;
        logic [7:0]  held;
        busy_cnt  = 0;
        prev_dv   = 1'b0;
        held      = '0;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (tx_dv) begin
                check("dv_single_cycle", {31'd0, prev_dv}, 32'd0);
                dv_count++;
                check("dv_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
                if (chk_gap && have_done) check("gap_after_done", cyc - done_cyc, 32'd3);
                if (chk_lat) begin
                    check("latency", cyc - wr_cyc, 32'd2);
                    chk_lat = 0;
                end
                tx_active = 1'b1;
                busy_cnt  = FRAME;
                held      = tx_byte;
                chk_stab  = 1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (chk_stab) check("tx_byte_stable", {24'd0, tx_byte}, {24'd0, held});
                if (busy_cnt == 0) begin
                    tx_done   = 1'b1;
                    tx_active = 1'b0;
                    done_cyc  = cyc;
                    have_done = 1;
                    if (chk_stab) rx_q.push_back(held);
                end
            end
            prev_dv = tx_dv;
        end
    end

    task automatic do_write(input logic [7:0] d, input logic accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        @(posedge clk);
        #2;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || tx_active || !empty) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_in_time", {31'd0, n < budget}, 32'd1);
        repeat (4) @(posedge clk);
        #2;
    endtask

    initial begin : main
        int unsigned d0;
        int unsigned n;

        for (int i = 0; i < 17; i++) begin
            vecs[i].data      = 8'h40 + 8'(i);
            vecs[i].accept    = (i < 16);
            vecs[i].exp_level = (i < 16) ? 5'(i + 1) : 5'd16;
            vecs[i].exp_full  = (i >= 15);
            vecs[i].exp_empty = 1'b0;
        end

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        stall   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_dv", {31'd0, tx_dv}, 32'd0);
        check("rst_byte", {24'd0, tx_byte}, 32'd0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
        check("rst_overflow", {31'd0, overflow}, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Single byte: latency and loopback.
        chk_lat = 1;
        wr_cyc  = cyc;
        do_write(8'hA1, 1'b1);
        wait_drain(300);
        check("single_dv_count", dv_count, 32'd1);
        check("single_rx_count", rx_q.size(), 32'd1);
        if (rx_q.size() != 0) check("single_rx", {24'd0, rx_q.pop_front()}, 32'hA1);

        // Burst of five: order and done-to-dv spacing.
        rx_q.delete();
        have_done = 0;
        chk_gap   = 1;
        d0        = dv_count;
        for (int i = 1; i <= 5; i++) do_write(8'(i), 1'b1);
        wait_drain(600);
        chk_gap = 0;
        check("burst_dv_count", dv_count - d0, 32'd5);
        check("burst_rx_count", rx_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) check("burst_rx", {24'd0, rx_q[i]}, i + 1);
        end

        // Fill while stalled: 17 writes, the last must be dropped.
        stall = 1'b1;
        for (int i = 0; i < 17; i++) begin
            do_write(vecs[i].data, vecs[i].accept);
            check("fill_level", {27'd0, level}, {27'd0, vecs[i].exp_level});
            check("fill_full", {31'd0, full}, {31'd0, vecs[i].exp_full});
            check("fill_empty", {31'd0, empty}, {31'd0, vecs[i].exp_empty});
        end
`ifdef UART_TX_FIFO_OVERFLOW_EN
        check("overflow_set", {31'd0, overflow}, 32'd1);
`endif
        stall = 1'b0;
        wait_drain(1000);

        // Simultaneous write and pop at level 4.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) do_write(8'h70 + 8'(i), 1'b1);
        check("lvl4_before", {27'd0, level}, 32'd4);
        stall = 1'b0;
        do_write(8'h74, 1'b1);
        check("lvl4_wr_pop", {27'd0, level}, 32'd4);
        wait_drain(600);

        // Pointer wrap: 40 write/pop pairs.
        d0 = dv_count;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) do_write(8'h80 + 8'(r * 4 + k), 1'b1);
            wait_drain(400);
        end
        check("wrap_dv_count", dv_count - d0, 32'd40);

        // Reset mid-BUSY with three bytes queued; write held high during reset.
        for (int i = 0; i < 4; i++) do_write(8'h90 + 8'(i), 1'b1);
        n = 0;
        while (!tx_active && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("busy_reached", {31'd0, n < 50}, 32'd1);
        @(posedge clk);
        #2;
        check("busy_level", {27'd0, level}, 32'd3);
        rst      = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 8'hEE;
        chk_stab = 0;
        exp_q.delete();
        @(posedge clk);
        #2;
        rst   = 1'b0;
        wr_en = 1'b0;
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_level", {27'd0, level}, 32'd0);
        check("midrst_full", {31'd0, full}, 32'd0);
        check("midrst_dv", {31'd0, tx_dv}, 32'd0);
        check("midrst_byte", {24'd0, tx_byte}, 32'd0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
`endif
        d0 = dv_count;
        repeat (40) @(posedge clk);
        #2;
        check("no_dv_after_rst", dv_count - d0, 32'd0);
        do_write(8'h5A, 1'b1);
        wait_drain(300);
        check("dv_after_rst_write", dv_count - d0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, byte width (matches uart_tx i_tx_byte).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_wr_en  input  1  write strobe, one byte per cycle.
REQ-006 SHALL have port i_wr_data  input  DATA_WIDTH  byte to enqueue.
REQ-007 SHALL have port o_full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port o_empty  output  1  FIFO holds 0 entries.
REQ-009 SHALL have port o_level  output  $clog2(DEPTH)+1  current entry count.
REQ-010 SHALL have port o_tx_dv  output  1  one-cycle start pulse to uart_tx i_tx_dv.
REQ-011 SHALL have port o_tx_byte  output  DATA_WIDTH  byte to uart_tx i_tx_byte, stable from the o_tx_dv pulse until i_tx_done.
REQ-012 SHALL have port i_tx_active  input  1  from uart_tx o_tx_active.
REQ-013 SHALL have port i_tx_done  input  1  from uart_tx o_tx_done (one-cycle pulse).
REQ-014 SHALL have port o_overflow  output  1  sticky write-when-full flag (present only under REQ-031).

Function
REQ-015 SHALL store bytes in first-in-first-out order in DEPTH entries, with wrapping read/write pointers one bit wider than the address.
REQ-016 SHALL enqueue i_wr_data on an edge where i_wr_en=1 and o_full=0.
REQ-017 SHALL drop a write while o_full=1, even if a pop occurs in the same cycle, and SHALL leave contents and pointers unchanged.
REQ-018 SHALL increment o_level on a write only, decrement it on a pop only, and leave it unchanged on simultaneous write and pop.
REQ-019 SHALL implement FSM states IDLE, LAUNCH, BUSY, GAP.
REQ-020 IDLE SHALL move to LAUNCH when o_empty=0 and i_tx_active=0, popping the head entry into the o_tx_byte register.
REQ-021 LAUNCH SHALL drive o_tx_dv=1 for exactly one cycle, then go to BUSY.
REQ-022 BUSY SHALL hold o_tx_dv=0 and o_tx_byte stable until i_tx_done=1, then go to GAP.
REQ-023 GAP SHALL last one cycle and then go to IDLE, giving uart_tx a cycle to return to idle.
REQ-024 Latency: with the FIFO empty and the FSM in IDLE, o_tx_dv SHALL be high in the second cycle after the edge that captures the write.
REQ-025 Back-to-back: the next o_tx_dv SHALL occur 3 cycles after i_tx_done when the FIFO is non-empty.
REQ-026 An i_tx_done pulse outside BUSY SHALL be ignored.
REQ-027 o_full and o_empty SHALL be registered-pointer derived, with no combinational path from i_wr_en.

Reset
REQ-028 On i_rst=1 at a clock edge, the block SHALL clear both pointers, set o_level=0, o_empty=1, o_full=0, o_tx_dv=0, o_tx_byte=0 and o_overflow=0, and set the FSM to IDLE.
REQ-029 Reset during LAUNCH or BUSY SHALL abandon the in-flight byte and discard queued data with no further o_tx_dv pulse; reset has priority over i_wr_en.
REQ-030 Storage array contents SHALL need no reset.

Configuration
REQ-031 With macro UART_TX_FIFO_OVERFLOW_EN defined, o_overflow SHALL set on any dropped write (REQ-017) and clear only on reset.
REQ-032 Without UART_TX_FIFO_OVERFLOW_EN, o_overflow and its logic SHALL be absent, and dropped writes SHALL be silent.

Structure
REQ-033 Shared package uart_pkg SHALL hold the FSM state encoding, DATA_WIDTH default, and the default BAUD_RATE 9600 and CLOCK_FREQUENCY 100_000_000 constants.
REQ-034 Storage and pointers SHALL be one sub-module, uart_sync_fifo, with the FSM in uart_tx_fifo.

Verification
REQ-035 Bench SHALL cover: reset, then one write of 0xA1 -> o_tx_dv pulses 2 cycles later with o_tx_byte=0xA1; a looped uart_tx and uart_rx (9600 baud, 100 MHz) gives o_rx_byte=0xA1.
REQ-036 Bench SHALL cover: burst writes of 0x01..0x05 -> five o_tx_dv pulses in order, each 3 cycles after the previous i_tx_done; rx sequence 0x01..0x05.
REQ-037 Bench SHALL cover: DEPTH=16, 17 writes while the FIFO is stalled -> o_full=1, o_level=16, 17th byte dropped, o_overflow=1 when the macro is defined.
REQ-038 Bench SHALL cover: simultaneous write and pop at o_level=4 -> o_level stays 4; pointer wrap after 40 write/pop pairs gives no data corruption.
REQ-039 Bench SHALL cover: i_rst asserted mid-BUSY with 3 bytes queued -> next cycle o_empty=1, o_level=0, and no o_tx_dv until a new write.
